// File: rtl/conv_window_engine_if.sv
// Strip-memory read port and result stream of conv_window_engine.
// master = engine side, slave = memory/consumer side.
interface conv_window_engine_if #(
    parameter int DATA_W = 9,
    parameter int OUT_W  = 9,
    parameter int ADDR_W = 16
);
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic [ADDR_W-1:0]        out_idx;
    logic                     out_last;

    modport master (
        output rd_en, rd_addr, out_valid, out_data, out_idx, out_last,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, out_data, out_idx, out_last,
        output rd_data, out_ready
    );
endinterface

// File: rtl/conv_window_engine.sv
// Sliding-window convolution over one feature-map strip with a loadable kernel.
// Optional feature macro: CONV_RELU_EN (clamp negative sums to zero before saturation).
module conv_window_engine #(
    parameter int DATA_W = 9,
    parameter int KSIZE  = 3,
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 30,
    parameter int STRIDE = 1,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 9,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1,
    localparam int KK     = KSIZE * KSIZE,
    localparam int KIDX_W = (KK > 1) ? $clog2(KK) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        base_addr_i,
    input  logic                     k_we_i,
    input  logic [KIDX_W-1:0]        k_idx_i,
    input  logic signed [DATA_W-1:0] k_data_i,
    output logic                     busy_o,
    output logic                     done_o,
    conv_window_engine_if.master     bus
);
    localparam int OW = (IMG_W - KSIZE) / STRIDE + 1;
    localparam int OH = (IMG_H - KSIZE) / STRIDE + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OW * OH - 1);
    localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] KSIZE_A  = ADDR_W'(KSIZE);
    localparam logic [ADDR_W-1:0] KLAST_A  = ADDR_W'(KSIZE - 1);
    localparam logic [KIDX_W-1:0] KK_LAST  = KIDX_W'(KK - 1);
    localparam logic [KIDX_W:0]   KK_EXT   = (KIDX_W + 1)'(KK);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EMIT, DONE} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic [ADDR_W-1:0]        winX_q, winX_d, winY_q, winY_d;
    logic [ADDR_W-1:0]        outIdx_q, outIdx_d;
    logic [ADDR_W-1:0]        row_q, row_d, col_q, col_d;
    logic [KIDX_W-1:0]        issCnt_q, issCnt_d, retCnt_q, retCnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, accR;
    logic [RD_LAT-1:0]        retPipe_q;
    logic signed [DATA_W-1:0] kern_q [KK];
    logic signed [2*DATA_W-1:0] prod;
    logic signed [OUT_W-1:0]  sat;
    logic [ADDR_W-1:0]        rdAddr;
    logic rdEn, retVld, issLast, retLast, isLast, hs, kWrite;

    assign rdEn    = (state_q == FETCH);
    assign retVld  = retPipe_q[RD_LAT-1];
    assign issLast = (issCnt_q == KK_LAST);
    assign retLast = (retCnt_q == KK_LAST);
    assign isLast  = (outIdx_q == LAST_IDX);
    assign hs      = (state_q == EMIT) && bus.out_ready;
    assign kWrite  = (state_q == IDLE) && k_we_i && ({1'b0, k_idx_i} < KK_EXT);
    assign prod    = kern_q[retCnt_q] * bus.rd_data;
    assign rdAddr  = base_q + (winY_q + row_q) * IMG_W_A + winX_q + col_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Returns arrive in issue order, so a plain counter tracks which coefficient they pair with.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = FETCH;
            FETCH:   if (issLast) state_d = DRAIN;
            DRAIN:   if (retVld && retLast) state_d = EMIT;
            EMIT:    if (hs) state_d = isLast ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        done_o        = 1'b0;
        busy_o        = (state_q != IDLE);
        case (state_q)
            FETCH: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = rdAddr;
            end
            EMIT: begin
                bus.out_valid = 1'b1;
                bus.out_data  = sat;
                bus.out_last  = isLast;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.out_idx = outIdx_q;

    always_comb begin
        accR = acc_q;
`ifdef CONV_RELU_EN
        if (acc_q < 0) accR = '0;
`endif
        if (accR > SAT_MAX)      sat = SAT_MAX[OUT_W-1:0];
        else if (accR < SAT_MIN) sat = SAT_MIN[OUT_W-1:0];
        else                     sat = accR[OUT_W-1:0];
    end

    always_comb begin
        base_d   = base_q;
        winX_d   = winX_q;
        winY_d   = winY_q;
        outIdx_d = outIdx_q;
        row_d    = row_q;
        col_d    = col_q;
        issCnt_d = issCnt_q;
        retCnt_d = retCnt_q;
        acc_d    = acc_q;
        if (state_q == IDLE && start_i) begin
            base_d   = base_addr_i;
            winX_d   = '0;
            winY_d   = '0;
            outIdx_d = '0;
            row_d    = '0;
            col_d    = '0;
            issCnt_d = '0;
            retCnt_d = '0;
            acc_d    = '0;
        end
        if (state_q == FETCH) begin
            issCnt_d = issCnt_q + 1'b1;
            if (col_q == KLAST_A) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        if (retVld) begin
            acc_d    = acc_q + ACC_W'(prod);
            retCnt_d = retCnt_q + 1'b1;
        end
        // Advance to the next window; wrap to the next row band when the window would overhang.
        if (hs && !isLast) begin
            acc_d    = '0;
            outIdx_d = outIdx_q + 1'b1;
            row_d    = '0;
            col_d    = '0;
            issCnt_d = '0;
            retCnt_d = '0;
            if (winX_q + STRIDE_A + KSIZE_A > IMG_W_A) begin
                winX_d = '0;
                winY_d = winY_q + STRIDE_A;
            end else begin
                winX_d = winX_q + STRIDE_A;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q    <= '0;
            winX_q    <= '0;
            winY_q    <= '0;
            outIdx_q  <= '0;
            row_q     <= '0;
            col_q     <= '0;
            issCnt_q  <= '0;
            retCnt_q  <= '0;
            acc_q     <= '0;
            retPipe_q <= '0;
            for (int i = 0; i < KK; i++) kern_q[i] <= '0;
        end else begin
            base_q    <= base_d;
            winX_q    <= winX_d;
            winY_q    <= winY_d;
            outIdx_q  <= outIdx_d;
            row_q     <= row_d;
            col_q     <= col_d;
            issCnt_q  <= issCnt_d;
            retCnt_q  <= retCnt_d;
            acc_q     <= acc_d;
            retPipe_q <= (retPipe_q << 1) | RD_LAT'(rdEn);
            if (kWrite) kern_q[k_idx_i] <= k_data_i;
        end
    end
endmodule

// File: tb/tb_conv_window_engine.sv
// Bench for conv_window_engine: three parameterisations share the control inputs
// (A: 5x5 RD_LAT=1, B: 7x7 stride 2 OUT_W=9, C: 5x5 RD_LAT=3).
module tb_conv_window_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start, kWe, readyA, readyB, readyC;
    logic [15:0] baseAddr;
    logic [3:0] kIdx;
    logic signed [8:0] kData;
    logic busyA, doneA, busyB, doneB, busyC, doneC;
    int cyc = 0;
    int nChecks = 0;
    int nFails = 0;
    int pixMode = 0;
    int kern [9];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_window_engine_if #(.DATA_W(9), .OUT_W(16), .ADDR_W(16)) ifA ();
    conv_window_engine_if #(.DATA_W(9), .OUT_W(9),  .ADDR_W(16)) ifB ();
    conv_window_engine_if #(.DATA_W(9), .OUT_W(16), .ADDR_W(16)) ifC ();

    conv_window_engine #(.DATA_W(9), .KSIZE(3), .IMG_W(5), .IMG_H(5), .STRIDE(1), .ACC_W(32),
                         .OUT_W(16), .ADDR_W(16), .RD_LAT(1)) dutA (
        .clk(clk), .reset(reset), .start_i(start), .base_addr_i(baseAddr), .k_we_i(kWe),
        .k_idx_i(kIdx), .k_data_i(kData), .busy_o(busyA), .done_o(doneA), .bus(ifA.master));
    conv_window_engine #(.DATA_W(9), .KSIZE(3), .IMG_W(7), .IMG_H(7), .STRIDE(2), .ACC_W(32),
                         .OUT_W(9), .ADDR_W(16), .RD_LAT(1)) dutB (
        .clk(clk), .reset(reset), .start_i(start), .base_addr_i(baseAddr), .k_we_i(kWe),
        .k_idx_i(kIdx), .k_data_i(kData), .busy_o(busyB), .done_o(doneB), .bus(ifB.master));
    conv_window_engine #(.DATA_W(9), .KSIZE(3), .IMG_W(5), .IMG_H(5), .STRIDE(1), .ACC_W(32),
                         .OUT_W(16), .ADDR_W(16), .RD_LAT(3)) dutC (
        .clk(clk), .reset(reset), .start_i(start), .base_addr_i(baseAddr), .k_we_i(kWe),
        .k_idx_i(kIdx), .k_data_i(kData), .busy_o(busyC), .done_o(doneC), .bus(ifC.master));

    assign ifA.out_ready = readyA;
    assign ifB.out_ready = readyB;
    assign ifC.out_ready = readyC;

    function automatic int pixelVal(input int a);
        return (pixMode == 1) ? 255 : (a & 255);
    endfunction

    // Strip memories: 1-cycle for A and B, 3-deep pipeline for C.
    logic signed [8:0] pipeC [3];
    always @(posedge clk) begin
        ifA.rd_data <= 9'(pixelVal(int'(ifA.rd_addr)));
        ifB.rd_data <= 9'(pixelVal(int'(ifB.rd_addr)));
        pipeC[0]    <= 9'(pixelVal(int'(ifC.rd_addr)));
        pipeC[1]    <= pipeC[0];
        pipeC[2]    <= pipeC[1];
    end
    assign ifC.rd_data = pipeC[2];

    int aData[$], aIdx[$], aLast[$], aHs[$];
    int bData[$], bIdx[$], bLast[$], bRd[$];
    int cData[$], cIdx[$], cLast[$], cHs[$];
    int aRdFirst, aValidFirst, aDoneCyc, aDoneCnt, aBusyFall;
    bit aBusyPrev = 1'b0;

    // Monitors sample on the falling edge; a valid&&ready seen here completes at the next rise.
    always @(negedge clk) begin
        if (ifA.out_valid && ifA.out_ready) begin
            aData.push_back(int'(ifA.out_data));
            aIdx.push_back(int'(ifA.out_idx));
            aLast.push_back(int'(ifA.out_last));
            aHs.push_back(cyc);
        end
        if (ifA.rd_en && aRdFirst < 0) aRdFirst = cyc;
        if (ifA.out_valid && aValidFirst < 0) aValidFirst = cyc;
        if (doneA) begin
            aDoneCyc = cyc;
            aDoneCnt++;
        end
        if (aBusyPrev && !busyA) aBusyFall = cyc;
        aBusyPrev = busyA;
        if (ifB.out_valid && ifB.out_ready) begin
            bData.push_back(int'(ifB.out_data));
            bIdx.push_back(int'(ifB.out_idx));
            bLast.push_back(int'(ifB.out_last));
        end
        if (ifB.rd_en) bRd.push_back(int'(ifB.rd_addr));
        if (ifC.out_valid && ifC.out_ready) begin
            cData.push_back(int'(ifC.out_data));
            cIdx.push_back(int'(ifC.out_idx));
            cLast.push_back(int'(ifC.out_last));
            cHs.push_back(cyc);
        end
    end

    typedef struct { int ox; int oy; int expData; int expLast; } smokeVec_t;
    typedef struct { int kval; int pix; int expA; int expB; } satVec_t;
    smokeVec_t smoke [9];
    satVec_t   satTab [3];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic setKernel(input int v);
        for (int i = 0; i < 9; i++) kern[i] = v;
    endtask

    // Starts a strip on all three engines; with load, slots 0..7 are written first
    // and slot 8 is written in the same cycle as start.
    task automatic applyStimulus(input logic [15:0] base, input bit load);
        aData.delete(); aIdx.delete(); aLast.delete(); aHs.delete();
        bData.delete(); bIdx.delete(); bLast.delete(); bRd.delete();
        cData.delete(); cIdx.delete(); cLast.delete(); cHs.delete();
        aRdFirst = -1; aValidFirst = -1; aDoneCyc = -1; aDoneCnt = 0; aBusyFall = -1;
        if (load) begin
            for (int i = 0; i < 8; i++) begin
                kWe = 1'b1; kIdx = 4'(i); kData = 9'(kern[i]);
                tick(1);
            end
            kIdx = 4'd8; kData = 9'(kern[8]);
        end
        baseAddr = base;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        kWe = 1'b0;
    endtask

    task automatic waitStrips(input bit stallB);
        int n;
        int held;
        bit stalled, rdSeen, moved;
        n = 0; stalled = 1'b0;
        while ((busyA || busyB || busyC) && n < 3000) begin
            if (stallB && !stalled && ifB.out_valid && ifB.out_idx == 16'd2) begin
                stalled = 1'b1; rdSeen = 1'b0; moved = 1'b0;
                readyB = 1'b0;
                held = int'(ifB.out_data);
                repeat (20) begin
                    tick(1); n++;
                    if (ifB.rd_en) rdSeen = 1'b1;
                    if (!ifB.out_valid || int'(ifB.out_data) != held || ifB.out_idx != 16'd2) moved = 1'b1;
                end
                checkOutput("stall_no_rd_en", int'(rdSeen), 0);
                checkOutput("stall_out_stable", int'(moved), 0);
                readyB = 1'b1;
            end
            tick(1); n++;
        end
        checkOutput("strip_timeout", int'(n >= 3000), 0);
        tick(2);
    endtask

    function automatic int modelOut(input int base, input int imgW, input int stride,
                                    input int outW, input int ox, input int oy);
        int acc, lim;
        acc = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                acc += kern[r*3 + c] * pixelVal(base + (oy*stride + r)*imgW + ox*stride + c);
`ifdef CONV_RELU_EN
        if (acc < 0) acc = 0;
`endif
        lim = 1 << (outW - 1);
        if (acc > lim - 1) acc = lim - 1;
        else if (acc < -lim) acc = -lim;
        return acc;
    endfunction

    task automatic pickQueues(input int sel, output int d[$], output int ix[$], output int l[$]);
        case (sel)
            0:       begin d = aData; ix = aIdx; l = aLast; end
            1:       begin d = bData; ix = bIdx; l = bLast; end
            default: begin d = cData; ix = cIdx; l = cLast; end
        endcase
    endtask

    task automatic checkStrip(input string tag, input int sel, input int base, input int imgW,
                              input int stride, input int outW, input int ow);
        int d[$], ix[$], l[$];
        pickQueues(sel, d, ix, l);
        checkOutput({tag, "_count"}, d.size(), 9);
        for (int k = 0; k < d.size() && k < 9; k++) begin
            checkOutput($sformatf("%s_data%0d", tag, k), d[k], modelOut(base, imgW, stride, outW, k % ow, k / ow));
            checkOutput($sformatf("%s_idx%0d", tag, k), ix[k], k);
            checkOutput($sformatf("%s_last%0d", tag, k), l[k], int'(k == 8));
        end
    endtask

    task automatic checkSmoke(input string tag, input int sel);
        int d[$], ix[$], l[$];
        pickQueues(sel, d, ix, l);
        checkOutput({tag, "_count"}, d.size(), 9);
        for (int k = 0; k < d.size() && k < 9; k++) begin
            checkOutput($sformatf("%s_data%0d", tag, k), d[k], smoke[k].expData);
            checkOutput($sformatf("%s_idx%0d", tag, k), ix[k], smoke[k].oy * 3 + smoke[k].ox);
            checkOutput($sformatf("%s_last%0d", tag, k), l[k], smoke[k].expLast);
        end
    endtask

    task automatic checkConst(input string tag, input int sel, input int expected);
        int d[$], ix[$], l[$];
        pickQueues(sel, d, ix, l);
        checkOutput({tag, "_count"}, d.size(), 9);
        for (int k = 0; k < d.size(); k++)
            checkOutput($sformatf("%s_data%0d", tag, k), d[k], expected);
    endtask

    task automatic checkIdleA(input string tag);
        checkOutput({tag, "_rd_en"}, int'(ifA.rd_en), 0);
        checkOutput({tag, "_rd_addr"}, int'(ifA.rd_addr), 0);
        checkOutput({tag, "_out_valid"}, int'(ifA.out_valid), 0);
        checkOutput({tag, "_out_data"}, int'(ifA.out_data), 0);
        checkOutput({tag, "_out_idx"}, int'(ifA.out_idx), 0);
        checkOutput({tag, "_out_last"}, int'(ifA.out_last), 0);
        checkOutput({tag, "_busy"}, int'(busyA), 0);
        checkOutput({tag, "_done"}, int'(doneA), 0);
        checkOutput({tag, "_busyC"}, int'(busyC), 0);
    endtask

    initial begin
        int n;
        start = 1'b0; kWe = 1'b0; kIdx = '0; kData = '0; baseAddr = '0;
        readyA = 1'b1; readyB = 1'b1; readyC = 1'b1;
        // 5x5 linear-address image, all-ones kernel: each result is 9x the window centre.
        smoke[0] = '{0, 0,  54, 0}; smoke[1] = '{1, 0,  63, 0}; smoke[2] = '{2, 0,  72, 0};
        smoke[3] = '{0, 1,  99, 0}; smoke[4] = '{1, 1, 108, 0}; smoke[5] = '{2, 1, 117, 0};
        smoke[6] = '{0, 2, 144, 0}; smoke[7] = '{1, 2, 153, 0}; smoke[8] = '{2, 2, 162, 1};
`ifdef CONV_RELU_EN
        satTab[0] = '{255, 1, 32767, 255};
        satTab[1] = '{ -1, 1,     0,   0};
        satTab[2] = '{  1, 1,  2295, 255};
`else
        satTab[0] = '{255, 1, 32767,  255};
        satTab[1] = '{ -1, 1, -2295, -256};
        satTab[2] = '{  1, 1,  2295,  255};
`endif

        tick(2);
        checkIdleA("reset");
        reset = 1'b0;
        tick(2);

        $display("[TB] smoke / stride / backpressure / latency");
        setKernel(1);
        applyStimulus(16'd0, 1'b1);
        waitStrips(1'b1);
        checkSmoke("smokeA", 0);
        checkSmoke("smokeC", 2);
        checkStrip("strideB", 1, 0, 7, 2, 9, 3);
        checkOutput("B_read_count", bRd.size(), 81);
        if (bRd.size() == 81) begin
            checkOutput("B_win1_first_addr", bRd[9], 2);
            checkOutput("B_win3_first_addr", bRd[27], 14);
        end
        checkOutput("A_first_window_latency", aValidFirst - aRdFirst, 10);
        for (int k = 0; k + 1 < aHs.size(); k++)
            checkOutput($sformatf("A_period%0d", k), aHs[k+1] - aHs[k], 11);
        for (int k = 0; k + 1 < cHs.size(); k++)
            checkOutput($sformatf("C_period%0d", k), cHs[k+1] - cHs[k], 13);
        if (aHs.size() > 0) checkOutput("A_done_after_last", aDoneCyc - aHs[aHs.size()-1], 1);
        checkOutput("A_done_width", aDoneCnt, 1);
        checkOutput("A_busy_fall_after_done", aBusyFall - aDoneCyc, 1);

        $display("[TB] mixed-sign kernel at offset base");
        for (int i = 0; i < 9; i++) kern[i] = i - 4;
        applyStimulus(16'd40, 1'b1);
        waitStrips(1'b0);
        checkStrip("mixA", 0, 40, 5, 1, 16, 3);
        checkStrip("mixB", 1, 40, 7, 2, 9, 3);
        checkStrip("mixC", 2, 40, 5, 1, 16, 3);

        $display("[TB] saturation table");
        for (int v = 0; v < 3; v++) begin
            setKernel(satTab[v].kval);
            pixMode = satTab[v].pix;
            applyStimulus(16'd0, 1'b1);
            waitStrips(1'b0);
            checkConst($sformatf("satA%0d", v), 0, satTab[v].expA);
            checkConst($sformatf("satB%0d", v), 1, satTab[v].expB);
            checkConst($sformatf("satC%0d", v), 2, satTab[v].expA);
        end
        pixMode = 0;

        $display("[TB] kernel protection");
        setKernel(1);
        applyStimulus(16'd0, 1'b1);
        kWe = 1'b1; kIdx = 4'd0; kData = 9'sd7;
        tick(3);
        kWe = 1'b0;
        waitStrips(1'b0);
        checkSmoke("protA", 0);
        applyStimulus(16'd0, 1'b0);
        waitStrips(1'b0);
        checkSmoke("protA_rerun", 0);

        $display("[TB] reset mid-strip");
        applyStimulus(16'd0, 1'b0);
        n = 0;
        while (!(aData.size() >= 4 && ifA.rd_en) && n < 200) begin
            tick(1); n++;
        end
        checkOutput("reach_window4_timeout", int'(n >= 200), 0);
        reset = 1'b1;
        #1;
        checkIdleA("midreset");
        tick(2);
        reset = 1'b0;
        tick(30);
        checkOutput("no_output_after_reset", aData.size(), 4);
        checkIdleA("post_release");
        applyStimulus(16'd0, 1'b0);
        waitStrips(1'b0);
        checkConst("cleared_kernelA", 0, 0);
        applyStimulus(16'd0, 1'b1);
        waitStrips(1'b0);
        checkSmoke("reloadA", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/conv_window_engine.md
# conv_window_engine

Parametrised sliding-window convolution engine for one horizontal strip of the feature map. It fetches each KSIZE×KSIZE patch from an external synchronous-read strip memory and multiply-accumulates it against a loadable kernel register file. Each result is saturated and emitted on a valid/ready stream with its output index. It is the successor to the fixed 3×3 / 224×30 strip convolution units and supports configurable kernel size, stride, geometry, widths and read latency.

## Interface
- DATA_W, 9: signed pixel and kernel width.
- KSIZE, 3: kernel edge; the window is KSIZE×KSIZE, KSIZE ≥ 1.
- IMG_W, 224: strip width in pixels.
- IMG_H, 30: strip height in pixels, ≥ KSIZE.
- STRIDE, 1: horizontal and vertical step, ≥ 1.
- ACC_W, 32: signed accumulator width.
- OUT_W, 9: signed output width.
- ADDR_W, 16: memory address and output index width.
- RD_LAT, 1: strip memory read latency in cycles, ≥ 1.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  strip base address; latched on an accepted start.
- k_we  in  1  kernel write strobe; honoured only in IDLE.
- k_idx  in  ceil(log2(KSIZE²))  kernel slot, row-major.
- k_data  in  DATA_W  signed kernel coefficient.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  memory read address.
- rd_data  in  DATA_W  signed read data; valid RD_LAT cycles after rd_en.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  saturated signed result.
- out_idx  out  ADDR_W  oy·OW + ox.
- out_last  out  1  asserted with the final window of the strip.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at strip completion.

## Operation
- Output geometry: OW = (IMG_W−KSIZE)/STRIDE+1 and OH = (IMG_H−KSIZE)/STRIDE+1, using integer division.
- States and transitions:
  - IDLE → FETCH on start. This clears the window row/column, clears out_idx and latches base_addr.
  - FETCH issues KSIZE² reads, one per cycle with rd_en=1. Read r,c has address base + (wy+r)·IMG_W + wx + c, in row-major order. After the last issue, FETCH → DRAIN.
  - DRAIN waits until all RD_LAT outstanding returns are accumulated, then DRAIN → EMIT.
  - EMIT holds out_valid, out_data, out_idx and out_last stable until out_valid && out_ready.
    - On handshake when not last: advance wx += STRIDE. If wx+KSIZE > IMG_W, set wx=0 and wy += STRIDE. Clear acc, increment out_idx and go to FETCH.
    - On handshake when last: go to DONE.
  - DONE pulses done for one cycle → IDLE.
- Arithmetic:
  - Each product is a full-precision 2·DATA_W signed value.
  - The accumulator is ACC_W signed and is cleared at window start. Overflow of ACC_W is not detected, since ACC_W ≥ 2·DATA_W + ceil(log2(KSIZE²)) by contract.
  - out_data saturates acc to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- The kernel register file holds KSIZE² signed entries. Writes are ignored while busy. Reset clears all entries to 0.
- start while busy is ignored.
- k_we and start asserted together in IDLE: the write takes effect first; the new coefficient is used by the strip.

## Timing
- Reset values: rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0, state IDLE.
- Reset mid-strip returns to IDLE immediately. In-flight read returns are discarded, and no partial result is emitted after reset release.
- First rd_en occurs the cycle after start is sampled.
- Window latency from the first read of a window to out_valid is KSIZE² + RD_LAT cycles. With the defaults this is 10 cycles.
- Window period is KSIZE² + RD_LAT + 1 cycles when out_ready is held high.
- out_ready low stalls in EMIT indefinitely. No reads are issued while stalled.
- done rises the cycle after the final handshake. busy falls the cycle after done.

## Configuration
- CONV_RELU_EN:
  - Defined: negative accumulator values are clamped to 0 before saturation. out_data is therefore in [0, 2^(OUT_W−1)−1].
  - Undefined: signed saturation only; negative results pass through.

## Test plan
- Smoke test: KSIZE=3, IMG_W=5, IMG_H=5, STRIDE=1, all-ones kernel, pixel value = linear address. Expect 9 outputs, out_idx 0..8, out_data[0]=54 with no saturation (OUT_W=16), and out_last on idx 8.
- Saturation: all pixels 255 and kernel all 255 with OUT_W=9. Expect every out_data=255. With CONV_RELU_EN and kernel all −1, expect out_data=0; without it, expect −256.
- Stride and backpressure: STRIDE=2, IMG_W=7, IMG_H=7. Expect 9 outputs, and rd_addr of window 1's first read = base+2. Holding out_ready low for 20 cycles must keep out_data stable with no rd_en.
- Read latency: RD_LAT=3 with identical data to the smoke test. Results must match, and the window period must be 13 cycles.
- Reset mid-strip: assert reset during the FETCH of window 4. Verify all outputs are 0 and kernel slots are 0. A new start with a reloaded kernel must reproduce the smoke-test results from out_idx 0.
- Kernel protection: k_we while busy writes 7 to slot 0. The strip results must be unchanged. A subsequent run must also show slot 0 unchanged.
